// File: rtl/pool_pkg.sv
// Shared types for the pooling feature-map interface: word and whole-window views
// used by the window loader and the pool wrapper.
package pool_pkg;
  localparam int DATA_W = 16;
  localparam int WIN    = 64;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] fm_word_t;
  typedef fm_word_t fm_win_t [0:WIN-1];
endpackage

// File: rtl/fm_bank.sv
// One window-sized register bank: single-lane write port, whole-window read,
// and a clear that takes priority over the write.
module fm_bank #(
  parameter int DATA_W = 16,
  parameter int WIN    = 64,
  parameter int AW     = $clog2(WIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata [0:WIN-1]
);

  logic [DATA_W-1:0] mem [0:WIN-1];

  // Clearing on release is what leaves the tail of a short window at zero.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int i = 0; i < WIN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < WIN; i++) rdata[i] = mem[i];
  end

endmodule

// File: rtl/fm_window_loader.sv
// Ping-pong window loader: one bank fills from the word stream while the other
// is presented on fm_out until the pool side takes it.
module fm_window_loader #(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int WIN    = pool_pkg::WIN,
  parameter int CNT_W  = pool_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] fm_out [0:WIN-1],
  output logic              fm_valid,
  input  logic              fm_ready,
  output logic              err_short,
  output logic [CNT_W-1:0]  win_count
);

  localparam int AW = $clog2(WIN);
  localparam logic [AW-1:0] LAST_LANE = AW'(WIN - 1);

  logic [1:0]        full;
  logic              wbank;
  logic              rbank;
  logic [AW-1:0]     wp;
  logic              accept;
  logic              close;
  logic              hand_off;
  logic [1:0]        we;
  logic [1:0]        clr;
  logic [DATA_W-1:0] rdata0 [0:WIN-1];
  logic [DATA_W-1:0] rdata1 [0:WIN-1];

  // Ready depends on registered state only, so no combinational path from the stream or the consumer.
  assign s_ready  = !full[wbank];
  assign accept   = s_valid && s_ready;
  assign close    = accept && (s_last || (wp == LAST_LANE));
  assign fm_valid = full[rbank];
  assign hand_off = fm_valid && fm_ready;

  assign we  = {accept && wbank, accept && !wbank};
  assign clr = {hand_off && rbank, hand_off && !rbank};

  fm_bank #(.DATA_W(DATA_W), .WIN(WIN), .AW(AW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we[0]),
    .waddr (wp),
    .wdata (s_data),
    .clr   (clr[0]),
    .rdata (rdata0)
  );

  fm_bank #(.DATA_W(DATA_W), .WIN(WIN), .AW(AW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we[1]),
    .waddr (wp),
    .wdata (s_data),
    .clr   (clr[1]),
    .rdata (rdata1)
  );

  always_comb begin
    for (int i = 0; i < WIN; i++) fm_out[i] = rbank ? rdata1[i] : rdata0[i];
  end

  // A close and a hand-off in the same cycle always target different banks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wp        <= '0;
      err_short <= 1'b0;
      win_count <= '0;
    end else begin
      err_short <= accept && s_last && (wp != LAST_LANE);
      if (hand_off) begin
        full[rbank] <= 1'b0;
        rbank       <= !rbank;
        win_count   <= win_count + 1'b1;
      end
      if (accept) begin
        if (close) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
          wp          <= '0;
        end else begin
          wp <= wp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_window_loader.sv
// Directed, table-driven and scoreboarded checks of the ping-pong window loader.
module tb_fm_window_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] fm_out [0:63];
  logic        fm_valid;
  logic        fm_ready = 1'b0;
  logic        err_short;
  logic [15:0] win_count;

  always #5 clk = ~clk;

  fm_window_loader #(.DATA_W(16), .WIN(64), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fm_out    (fm_out),
    .fm_valid  (fm_valid),
    .fm_ready  (fm_ready),
    .err_short (err_short),
    .win_count (win_count)
  );

  int total = 0;
  int bad = 0;
  int stalls = 0;
  int exp_cnt = 0;

  typedef struct {
    int          len;
    logic [15:0] base;
    logic        exp_err;
  } frame_vec_t;

  frame_vec_t vecs [0:4];

  // scoreboard state
  bit          mon_en = 1'b0;
  logic [15:0] word_q [$];
  logic [15:0] cur [0:63];
  int          cur_n = 0;
  int          handed = 0;
  bit          held_prev = 1'b0;
  logic [15:0] snap [0:63];
  bit          rdone = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    fm_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    int g;
    s_data = d;
    s_valid = 1'b1;
    s_last = last;
    if (!s_ready) stalls++;
    g = 0;
    while (!s_ready && g < 1000) begin
      tick();
      g++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: s_ready low for %0d cycles, want high", g);
    end
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  function automatic int lane_diff(input logic [15:0] base, input int len);
    int n = 0;
    logic [15:0] e;
    for (int k = 0; k < 64; k++) begin
      e = (k < len) ? base + 16'(k) : 16'h0000;
      if (fm_out[k] !== e) n++;
    end
    return n;
  endfunction

  task automatic clear_model();
    word_q.delete();
    cur_n = 0;
    handed = 0;
    held_prev = 1'b0;
  endtask

  // Independent reference: windows formed from accepted words, compared at each hand-off.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fm_valid && fm_ready) begin
        if (word_q.size() < 64) begin
          chk("sb_underflow", word_q.size(), 64);
        end else begin
          int nb = 0;
          logic [15:0] w;
          for (int k = 0; k < 64; k++) begin
            w = word_q.pop_front();
            if (fm_out[k] !== w) nb++;
          end
          chk("sb_window", nb, 0);
          handed++;
        end
      end
      if (held_prev && fm_valid) begin
        int nd = 0;
        for (int k = 0; k < 64; k++) if (fm_out[k] !== snap[k]) nd++;
        chk("sb_stable", nd, 0);
      end
      held_prev = fm_valid && !fm_ready;
      for (int k = 0; k < 64; k++) snap[k] = fm_out[k];
      if (s_valid && s_ready) begin
        cur[cur_n] = s_data;
        cur_n++;
        if (cur_n == 64 || s_last) begin
          for (int k = 0; k < 64; k++) word_q.push_back((k < cur_n) ? cur[k] : 16'h0000);
          cur_n = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{10, 16'hA000, 1'b1};
    vecs[1] = '{1,  16'h5555, 1'b1};
    vecs[2] = '{63, 16'h0100, 1'b1};
    vecs[3] = '{64, 16'hFFC0, 1'b0};
    vecs[4] = '{2,  16'h7FFF, 1'b1};

    // reset state
    tick();
    do_reset();
    chk("rst_fm_valid", fm_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_err_short", err_short, 0);
    chk("rst_win_count", win_count, 0);
    chk("rst_fm_out", lane_diff(16'h0, 0), 0);

    // one full window with s_last on word 64, consumer ready
    fm_ready = 1'b1;
    for (int i = 1; i <= 64; i++) push(16'(i), i == 64);
    chk("w1_fm_valid", fm_valid, 1);
    chk("w1_lane0", fm_out[0], 16'h0001);
    chk("w1_lane63", fm_out[63], 16'h0040);
    chk("w1_err_short", err_short, 0);
    tick();
    chk("w1_win_count", win_count, 1);
    chk("w1_released", fm_valid, 0);
    fm_ready = 1'b0;

    // backpressure with both banks full
    for (int i = 1; i <= 128; i++) push(16'(i), 1'b0);
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_fm_valid", fm_valid, 1);
    chk("bp_win_a", lane_diff(16'h0001, 64), 0);
    s_data = 16'd129;
    s_valid = 1'b1;
    repeat (3) tick();
    chk("bp_still_stalled", s_ready, 0);
    chk("bp_win_a_stable", lane_diff(16'h0001, 64), 0);
    fm_ready = 1'b1;
    tick();
    fm_ready = 1'b0;
    chk("bp_s_ready_back", s_ready, 1);
    chk("bp_count2", win_count, 2);
    chk("bp_win_b", lane_diff(16'h0041, 64), 0);
    for (int i = 129; i <= 192; i++) push(16'(i), 1'b0);
    chk("bp_full_again", s_ready, 0);
    fm_ready = 1'b1;
    tick();
    fm_ready = 1'b0;
    chk("bp_count3", win_count, 3);
    chk("bp_win_c", lane_diff(16'h0081, 64), 0);
    fm_ready = 1'b1;
    tick();
    fm_ready = 1'b0;
    chk("bp_count4", win_count, 4);
    chk("bp_empty", fm_valid, 0);
    exp_cnt = 4;

    // table of single-window frames, short and exact
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].len; k++)
        push(vecs[v].base + 16'(k), k == vecs[v].len - 1);
      chk($sformatf("tbl%0d_err", v), err_short, vecs[v].exp_err);
      chk($sformatf("tbl%0d_valid", v), fm_valid, 1);
      chk($sformatf("tbl%0d_lanes", v), lane_diff(vecs[v].base, vecs[v].len), 0);
      tick();
      chk($sformatf("tbl%0d_err_pulse", v), err_short, 0);
      fm_ready = 1'b1;
      tick();
      fm_ready = 1'b0;
      exp_cnt++;
      chk($sformatf("tbl%0d_count", v), win_count, exp_cnt);
    end

    // reset while one window is held and the next is part filled
    for (int k = 0; k < 64; k++) push(16'h3000 + 16'(k), 1'b0);
    for (int k = 0; k < 30; k++) push(16'h3100 + 16'(k), 1'b0);
    chk("mid_fm_valid", fm_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", fm_valid, 0);
    chk("mid_rst_count", win_count, 0);
    chk("mid_rst_fm_out", lane_diff(16'h0, 0), 0);
    chk("mid_rst_s_ready", s_ready, 1);
    for (int k = 0; k < 64; k++) push(16'h4000 + 16'(k), k == 63);
    chk("mid_clean_lanes", lane_diff(16'h4000, 64), 0);
    chk("mid_clean_err", err_short, 0);
    fm_ready = 1'b1;
    tick();
    fm_ready = 1'b0;
    chk("mid_clean_count", win_count, 1);

    // continuous stream with consumer always ready
    do_reset();
    clear_model();
    mon_en = 1'b1;
    fm_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 640; i++) push(16'(i * 7 + 3), 1'b0);
    chk("cont_stalls", stalls, 0);
    tick();
    tick();
    chk("cont_handed", handed, 10);
    chk("cont_win_count", win_count, 10);
    chk("cont_q_empty", word_q.size(), 0);
    mon_en = 1'b0;

    // random valid/ready traffic against the scoreboard
    do_reset();
    clear_model();
    mon_en = 1'b1;
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          push(16'($urandom), (i == 9999) || ($urandom_range(0, 199) == 0));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          fm_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    fm_ready = 1'b1;
    repeat (5) tick();
    chk("rnd_q_empty", word_q.size(), 0);
    chk("rnd_no_partial", cur_n, 0);
    chk("rnd_win_count", win_count, 16'(handed));
    chk("rnd_drained", fm_valid, 0);
    mon_en = 1'b0;
    fm_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
